// File: rtl/mips_harvard_wait_ctrl.sv
// Wait-state controller that stretches each MIPS CPU step to the memory latency.
// Optional stall performance counter is enabled with `define MIPS_WAIT_PERF_EN.
module mips_harvard_wait_ctrl #(
  parameter int INSTR_WAIT = 1,
  parameter int DATA_WAIT  = 2,
  parameter int CNT_W      = 4,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_en,
  input  logic              cpu_data_read,
  input  logic              cpu_data_write,
  input  logic              mem_busy,
  output logic              clk_enable,
  output logic              mem_data_read,
  output logic              mem_data_write,
  output logic [PERF_W-1:0] stall_cycles
);

  if (INSTR_WAIT < 0 || INSTR_WAIT >= (1 << CNT_W)) begin : g_instr_wait_range
    $error("INSTR_WAIT does not fit in CNT_W bits");
  end
  if (DATA_WAIT < 0 || DATA_WAIT >= (1 << CNT_W)) begin : g_data_wait_range
    $error("DATA_WAIT does not fit in CNT_W bits");
  end

  typedef enum logic [1:0] {ISSUE, WAIT, STEP} state_t;

  localparam logic [CNT_W-1:0] INSTR_N = CNT_W'(INSTR_WAIT);
  localparam logic [CNT_W-1:0] DATA_N  = CNT_W'(DATA_WAIT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] need;
  logic             data_access;
  logic             pass_through;

  assign data_access  = cpu_data_read | cpu_data_write;
  assign need         = (data_access && (DATA_N > INSTR_N)) ? DATA_N : INSTR_N;
  assign pass_through = (state == ISSUE) && (need == '0) && !mem_busy;

  // The enable must be combinational so zero-wait steps pass straight through.
  assign clk_enable     = !reset && run_en && (pass_through || (state == STEP));
  assign mem_data_read  = cpu_data_read & run_en & ~reset;
  assign mem_data_write = cpu_data_write & clk_enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ISSUE;
      cnt   <= '0;
    end else begin
      case (state)
        ISSUE: begin
          if (run_en) begin
            if (need == '0) begin
              if (mem_busy) begin
                cnt   <= ONE;
                state <= WAIT;
              end
            end else if (need == ONE) begin
              if (mem_busy) begin
                cnt   <= ONE;
                state <= WAIT;
              end else begin
                state <= STEP;
              end
            end else begin
              cnt   <= need - ONE;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // mem_busy only matters at the final wait position
          if (run_en) begin
            if (cnt > ONE) begin
              cnt <= cnt - ONE;
            end else if (!mem_busy) begin
              state <= STEP;
            end
          end
        end
        STEP: begin
          if (run_en) begin
            state <= ISSUE;
          end
        end
        default: begin
          state <= ISSUE;
        end
      endcase
    end
  end

`ifdef MIPS_WAIT_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (run_en && !clk_enable && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mips_harvard_wait_ctrl.sv
// Randomized bench for mips_harvard_wait_ctrl with a step-level stall model.
module tb_mips_harvard_wait_ctrl;
  localparam int INSTR_WAIT = 1;
  localparam int DATA_WAIT  = 2;
  localparam int CNT_W      = 4;
  localparam int PERF_W     = 32;

  logic clk = 1'b0;
  logic reset, run_en, rd, wr, busy;
  logic ce, mrd, mwr;
  logic [PERF_W-1:0] stall;
  logic zw_ce, zw_mrd, zw_mwr;
  logic [PERF_W-1:0] zw_stall;

  int checks = 0;
  int errors = 0;

  // step model: stall positions completed vs. required
  bit     m_active, m_ready;
  int     m_req, m_done;
  longint m_stall;

  always #5 clk = ~clk;

  mips_harvard_wait_ctrl #(
    .INSTR_WAIT(INSTR_WAIT), .DATA_WAIT(DATA_WAIT), .CNT_W(CNT_W), .PERF_W(PERF_W)
  ) u_dut (
    .clk(clk), .reset(reset), .run_en(run_en), .cpu_data_read(rd),
    .cpu_data_write(wr), .mem_busy(busy), .clk_enable(ce),
    .mem_data_read(mrd), .mem_data_write(mwr), .stall_cycles(stall)
  );

  mips_harvard_wait_ctrl #(
    .INSTR_WAIT(0), .DATA_WAIT(0), .CNT_W(CNT_W), .PERF_W(PERF_W)
  ) u_zw (
    .clk(clk), .reset(reset), .run_en(run_en), .cpu_data_read(rd),
    .cpu_data_write(wr), .mem_busy(1'b0), .clk_enable(zw_ce),
    .mem_data_read(zw_mrd), .mem_data_write(zw_mwr), .stall_cycles(zw_stall)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int step_need(input logic d_rd, input logic d_wr);
    int n;
    n = (d_rd | d_wr) ? DATA_WAIT : 0;
    if (INSTR_WAIT > n) n = INSTR_WAIT;
    return n % (1 << CNT_W);
  endfunction

  task automatic cycle(input logic r_rst, input logic r_run, input logic r_rd,
                       input logic r_wr, input logic r_busy,
                       input int lit_ce, input int lit_stall);
    bit exp_ce;
    @(negedge clk);
    reset = r_rst; run_en = r_run; rd = r_rd; wr = r_wr; busy = r_busy;
    #1;
    exp_ce = 1'b0;
    if (r_rst) begin
      exp_ce = 1'b0;
    end else if (m_ready) begin
      exp_ce = r_run;
      if (r_run) begin
        m_ready  = 1'b0;
        m_active = 1'b0;
      end
    end else if (!m_active) begin
      if (r_run) begin
        m_req = step_need(r_rd, r_wr);
        if (m_req == 0 && !r_busy) begin
          exp_ce = 1'b1;
        end else begin
          if (m_req == 0) m_req = 1;
          m_active = 1'b1;
          m_done   = (r_busy && m_req == 1) ? 0 : 1;
          if (m_done == m_req) m_ready = 1'b1;
        end
      end
    end else if (r_run) begin
      if (!(m_done + 1 == m_req && r_busy)) m_done++;
      if (m_done == m_req) m_ready = 1'b1;
    end

    check("clk_enable", ce, exp_ce);
    check("mem_data_read", mrd, r_rd & r_run & ~r_rst);
    check("mem_data_write", mwr, r_wr & exp_ce);
    check("zw_clk_enable", zw_ce, r_run & ~r_rst);
    check("zw_mem_data_write", zw_mwr, r_wr & r_run & ~r_rst);
`ifdef MIPS_WAIT_PERF_EN
    check("stall_cycles", stall, m_stall);
    check("zw_stall_cycles", zw_stall, 0);
    if (lit_stall >= 0) check("stall_literal", stall, lit_stall);
`else
    check("stall_cycles_tied", stall, 0);
`endif
    if (lit_ce >= 0) check("clk_enable_literal", ce, lit_ce);

    if (r_rst) begin
      m_active = 1'b0; m_ready = 1'b0; m_done = 0; m_stall = 0;
    end else if (r_run && !exp_ce && m_stall < ((longint'(1) << PERF_W) - 1)) begin
      m_stall++;
    end
    if (r_rst) begin
      m_active = 1'b0;
      m_ready  = 1'b0;
    end
  endtask

  initial begin
    int lits_fetch[4] = '{0, 1, 0, 1};
    int lits_sw[3]    = '{0, 0, 1};
    int lits_lw[6]    = '{0, 0, 0, 0, 0, 1};
    int lits_run[7]   = '{0, 0, 0, 0, 0, 0, 1};
    reset = 1'b1; run_en = 1'b0; rd = 1'b0; wr = 1'b0; busy = 1'b0;
    m_active = 1'b0; m_ready = 1'b0; m_req = 0; m_done = 0; m_stall = 0;

    cycle(1, 1, 1, 1, 0, 0, -1);
    cycle(1, 1, 0, 0, 0, 0, -1);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // fetch-only steps: 0,1,0,1
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, lits_fetch[i], -1);

    // sw from a fresh reset: two stalls then the committing cycle
    cycle(1, 1, 0, 0, 0, 0, -1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, 0, lits_sw[i], -1);
    cycle(0, 0, 0, 0, 0, 0, 2);

    // lw with mem_busy held three cycles at the final wait position
    for (int i = 0; i < 6; i++)
      cycle(0, 1, 1, 0, (i >= 1 && i <= 3), lits_lw[i], -1);

    // run_en dropped for four cycles mid-wait
    for (int i = 0; i < 7; i++)
      cycle(0, !(i >= 1 && i <= 4), 1, 0, 0, lits_run[i], -1);

    // reset while waiting at the final position
    cycle(0, 1, 1, 0, 0, 0, -1);
    cycle(1, 1, 1, 0, 0, 0, -1);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 1, -1);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(199) == 0), ($urandom_range(9) < 8),
            $urandom_range(1), $urandom_range(1), ($urandom_range(9) < 3), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
